periph_addr_dec_req_tracked: RTL and testbench
==============================================

# periph_addr_dec_req_tracked

Per-master request address decoder for the peripheral interconnect. It turns one master request into a one-hot request toward N_SLAVE arbitration trees and routes the grant back. It also tracks outstanding transactions, so responses to a master return in order. It sits between each PE master port and the peripheral arbitration trees, and adds an optional internal error responder for unmapped addresses.

## Interface
- ID_WIDTH, 17: width of the routing ID attached to requests
- ID, 1: constant ID driven on data_ID_o
- N_SLAVE, 16: number of target ports; index N_SLAVE-1 is the default/external port
- LOG_CLUSTER, 5: width of CLUSTER_ID
- ADDR_WIDTH, 32: address width; must be >= 32
- PE_ROUTING_LSB, 16: LSB of the target-index field
- PE_ROUTING_MSB, 19: MSB of the target-index field
- CLUSTER_ALIAS, 0: enables the alias window
- CLUSTER_ALIAS_BASE, 12'h000: alias base for address bits [31:20]
- MAX_OUTSTANDING, 4: maximum number of accepted but unanswered transactions; must be >= 1
- ERR_SLAVE_EN, 0: when 1, unmapped addresses go to the internal error responder instead of port N_SLAVE-1
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- CLUSTER_ID  in  LOG_CLUSTER  cluster index; quasi-static
- data_req_i  in  1  master request
- data_add_i  in  ADDR_WIDTH  master address
- data_gnt_o  out  1  grant to master
- data_req_o  out  N_SLAVE  one-hot request to the arbitration trees
- data_gnt_i  in  N_SLAVE  grants from the arbitration trees
- data_ID_o  out  ID_WIDTH  constant ID
- data_r_valid_i  in  1  response beat delivered to this master by the response path
- err_r_valid_o  out  1  error-responder response valid
- err_o  out  1  error flag; equals err_r_valid_o

## Operation
- Window test on A = data_add_i[31:20], with PE_BASE = 12'h100 + (CLUSTER_ID<<2) + 2:
  - hit if A == PE_BASE
  - hit if CLUSTER_ALIAS and A == CLUSTER_ALIAS_BASE+2
- Target selection:
  - On a hit, idx = data_add_i[MSB:LSB].
  - If idx >= N_SLAVE-1, tgt = N_SLAVE-1.
  - On a miss, tgt = ERR (encoding N_SLAVE) when ERR_SLAVE_EN is 1, otherwise N_SLAVE-1.
- Registered state:
  - cnt: 0..MAX_OUTSTANDING, width $clog2(MAX_OUTSTANDING+1)
  - last_tgt: $clog2(N_SLAVE+1) bits
  - err_pend
- Issue condition: allow = (cnt==0) || (tgt==last_tgt && cnt<MAX_OUTSTANDING).
- When allow is 1 and tgt != ERR:
  - data_req_o[tgt] = data_req_i; all other bits are 0.
  - data_gnt_o = data_gnt_i[tgt].
- When allow is 1 and tgt == ERR:
  - data_req_o = 0.
  - data_gnt_o = data_req_i.
- When allow is 0: data_req_o = 0 and data_gnt_o = 0. The master holds its request (stall).
- Handshake (data_req_i & data_gnt_o):
  - last_tgt <= tgt.
  - cnt increments.
  - If tgt == ERR, err_pend <= 1.
- Error responder:
  - err_r_valid_o = err_pend for exactly 1 cycle, then err_pend clears.
  - A back-to-back ERR handshake re-sets err_pend, giving one response per cycle.
- Decrement sources: data_r_valid_i | err_r_valid_o. At most one is active per cycle, which ordering guarantees.
- Simultaneous handshake and response in the same cycle: cnt is unchanged and last_tgt still updates.
- A response arriving while cnt==0 is ignored: cnt stays 0. Flagged by an assertion in simulation.
- Switching target: only possible once cnt has drained to 0. This preserves response ordering across targets, including ERR.
- data_ID_o = ID always.

## Timing
- Request and grant paths are combinational from data_req_i, data_add_i, data_gnt_i and registered state. Zero added latency.
- cnt, last_tgt and err_pend update on the rising clk edge.
- Error response latency: exactly 1 cycle after the ERR handshake.
- Reset (rst_n low, asynchronous):
  - cnt=0, last_tgt=0, err_pend=0.
  - Hence err_r_valid_o=0 and err_o=0.
  - data_req_o and data_gnt_o follow combinationally with allow=1.
- Reset asserted mid-transaction drops all outstanding state. Responses arriving after release are ignored per the cnt==0 rule.
- Full: cnt==MAX_OUTSTANDING blocks further issue until a response arrives. The decrement and the next grant may occur in the same cycle only on the following edge (allow uses registered cnt).

## Test plan
- Decode: N_SLAVE=5, CLUSTER_ID=1, address 0x1063_0000, req=1, gnt_i=5'b01000 -> data_req_o=5'b01000, data_gnt_o=1, cnt becomes 1.
- Clamp and default: address 0x106F_0000 -> data_req_o=5'b10000. Address 0x2000_0000 with ERR_SLAVE_EN=0 -> data_req_o=5'b10000.
- Same-target streaming and full, MAX_OUTSTANDING=2:
  - Three back-to-back requests to slave 2 with no r_valid -> two grants, third stalls (data_gnt_o=0, data_req_o=0).
  - Pulse data_r_valid_i -> third is granted on the next cycle.
- Target switch blocking:
  - One outstanding to slave 1, then a request to slave 3 -> stalls.
  - After r_valid (cnt=0) -> slave 3 is requested.
- Error responder, ERR_SLAVE_EN=1, address 0x2000_0000:
  - data_gnt_o=1 with data_req_o=0.
  - err_r_valid_o=1 and err_o=1 for one cycle, the next cycle.
  - cnt returns to 0.
- Reset and corner cases:
  - Assert rst_n low with cnt=2 -> cnt=0 and err_r_valid_o=0 immediately.
  - Stray data_r_valid_i with cnt=0 -> cnt stays 0.
  - Simultaneous handshake and response -> cnt unchanged.

Source files
------------

// File: rtl/periph_addr_dec_req_tracked.sv
// Per-master request address decoder with outstanding-transaction tracking.
// Steers one master request to a single target port and returns that port's grant.
// A new target is only accepted once every earlier transaction has been answered,
// so responses come back to the master in issue order.
// Unmapped addresses go either to the default port or to an internal error
// responder that answers exactly one cycle after the handshake.
module periph_addr_dec_req_tracked #(
    parameter int unsigned ID_WIDTH           = 17,
    parameter int unsigned ID                 = 1,
    parameter int unsigned N_SLAVE            = 16,
    parameter int unsigned LOG_CLUSTER        = 5,
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned PE_ROUTING_LSB     = 16,
    parameter int unsigned PE_ROUTING_MSB     = 19,
    parameter bit          CLUSTER_ALIAS      = 1'b0,
    parameter logic [11:0] CLUSTER_ALIAS_BASE = 12'h000,
    parameter int unsigned MAX_OUTSTANDING    = 4,
    parameter bit          ERR_SLAVE_EN       = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LOG_CLUSTER-1:0] CLUSTER_ID,
    input  logic                   data_req_i,
    input  logic [ADDR_WIDTH-1:0]  data_add_i,
    output logic                   data_gnt_o,
    output logic [N_SLAVE-1:0]     data_req_o,
    input  logic [N_SLAVE-1:0]     data_gnt_i,
    output logic [ID_WIDTH-1:0]    data_ID_o,
    input  logic                   data_r_valid_i,
    output logic                   err_r_valid_o,
    output logic                   err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TGT_W = $clog2(N_SLAVE + 1);
    localparam int unsigned IDX_W = PE_ROUTING_MSB - PE_ROUTING_LSB + 1;

    localparam logic [TGT_W-1:0] TGT_DEF = TGT_W'(N_SLAVE - 1);
    localparam logic [TGT_W-1:0] TGT_ERR = TGT_W'(N_SLAVE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]   r_cnt;
    logic [TGT_W-1:0]   r_last_tgt;
    logic               r_err_pend;

    logic [11:0]        w_win;
    logic [11:0]        w_pe_base;
    logic [11:0]        w_alias_base;
    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic [TGT_W-1:0]   w_tgt;
    logic               w_is_err;
    logic               w_allow;
    logic [N_SLAVE-1:0] w_onehot;
    logic               w_hs;
    logic               w_dec;
    logic               w_dec_eff;
    logic               w_unused_addr;

    assign w_win         = data_add_i[31:20];
    assign w_pe_base     = 12'h102 + 12'({CLUSTER_ID, 2'b00});
    assign w_alias_base  = CLUSTER_ALIAS_BASE + 12'h002;
    assign w_hit         = (w_win == w_pe_base) || (CLUSTER_ALIAS && (w_win == w_alias_base));
    assign w_idx         = data_add_i[PE_ROUTING_MSB:PE_ROUTING_LSB];
    assign w_unused_addr = ^data_add_i;

    // Target selection: in-window index clamped to the default port, misses to default or ERR.
    always_comb begin
        w_tgt = TGT_DEF;
        if (w_hit) begin
            if (32'(w_idx) < 32'(N_SLAVE - 1)) begin
                w_tgt = TGT_W'(w_idx);
            end
        end else if (ERR_SLAVE_EN) begin
            w_tgt = TGT_ERR;
        end
    end

    assign w_is_err = (w_tgt == TGT_ERR);
    assign w_allow  = (r_cnt == '0) || ((w_tgt == r_last_tgt) && (r_cnt < CNT_MAX));
    assign w_onehot = N_SLAVE'(1) << w_tgt;

    // Request/grant steering; a blocked request sees neither request nor grant (stall).
    always_comb begin
        data_req_o = '0;
        data_gnt_o = 1'b0;
        if (w_allow) begin
            if (w_is_err) begin
                data_gnt_o = data_req_i;
            end else begin
                data_req_o = data_req_i ? w_onehot : '0;
                data_gnt_o = |(data_gnt_i & w_onehot);
            end
        end
    end

    assign w_hs      = data_req_i & data_gnt_o;
    assign w_dec     = data_r_valid_i | r_err_pend;
    // A response with nothing outstanding is stray and must not underflow the counter.
    assign w_dec_eff = w_dec && (r_cnt != '0);

    // Outstanding counter, last target and one-cycle error response state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_last_tgt <= '0;
            r_err_pend <= 1'b0;
        end else begin
            if (w_hs) begin
                r_last_tgt <= w_tgt;
            end
            r_err_pend <= w_hs && w_is_err;
            if (w_hs && !w_dec_eff) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_hs && w_dec_eff) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign err_r_valid_o = r_err_pend;
    assign err_o         = r_err_pend;
    assign data_ID_o     = ID_WIDTH'(ID);

    // Flag responses that arrive with no transaction outstanding.
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!rst_n) !(w_dec && (r_cnt == '0)))
        else $warning("response with no outstanding transaction ignored");

endmodule

// File: tb/tb_periph_addr_dec_req_tracked.sv
// Randomised self-checking bench: two decoder instances (error responder on /
// off) share request inputs and are compared every cycle against a behavioural
// model of target decode, ordering rule, outstanding count and error response.
module tb_periph_addr_dec_req_tracked;

    logic        clk;
    logic        rst_n;
    logic [4:0]  cid;
    logic        req_i;
    logic [31:0] add_i;
    logic [4:0]  gnt_i;
    logic        rv [2];

    logic [4:0]  req_o  [2];
    logic        gnt_o  [2];
    logic [16:0] id_o   [2];
    logic        errv_o [2];
    logic        err_o  [2];

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt  [2];
    int m_last [2];
    bit m_err  [2];

    periph_addr_dec_req_tracked #(
        .N_SLAVE(5), .MAX_OUTSTANDING(2), .ERR_SLAVE_EN(1'b1), .CLUSTER_ALIAS(1'b1)
    ) dut_e (
        .clk(clk), .rst_n(rst_n), .CLUSTER_ID(cid),
        .data_req_i(req_i), .data_add_i(add_i), .data_gnt_o(gnt_o[0]),
        .data_req_o(req_o[0]), .data_gnt_i(gnt_i), .data_ID_o(id_o[0]),
        .data_r_valid_i(rv[0]), .err_r_valid_o(errv_o[0]), .err_o(err_o[0])
    );

    periph_addr_dec_req_tracked #(
        .N_SLAVE(5), .MAX_OUTSTANDING(2), .ERR_SLAVE_EN(1'b0), .CLUSTER_ALIAS(1'b0)
    ) dut_d (
        .clk(clk), .rst_n(rst_n), .CLUSTER_ID(cid),
        .data_req_i(req_i), .data_add_i(add_i), .data_gnt_o(gnt_o[1]),
        .data_req_o(req_o[1]), .data_gnt_i(gnt_i), .data_ID_o(id_o[1]),
        .data_r_valid_i(rv[1]), .err_r_valid_o(errv_o[1]), .err_o(err_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int dut_cnt(input int k);
        return (k == 0) ? int'(dut_e.r_cnt) : int'(dut_d.r_cnt);
    endfunction

    // Target port for an address: 0..3 slaves, 4 default port, 5 error responder.
    function automatic int model_tgt(input logic [31:0] a, input int c, input bit alias_en, input bit err_en);
        int win;
        int idx;
        int base;
        win  = int'(a[31:20]);
        idx  = int'(a[19:16]);
        base = (256 + c * 4 + 2) % 4096;
        if (win == base || (alias_en && win == 2)) return (idx >= 4) ? 4 : idx;
        return err_en ? 5 : 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_last[k] = 0;
            m_err[k]  = 1'b0;
        end
    endtask

    // One cycle: drive at negedge, check combinational and registered outputs, advance the model.
    task automatic step(input logic [4:0] c, input bit req, input logic [31:0] addr,
                        input logic [4:0] gnt, input bit rv0, input bit rv1);
        @(negedge clk);
        cid   = c;
        req_i = req;
        add_i = addr;
        gnt_i = gnt;
        rv[0] = rv0;
        rv[1] = rv1;
        #1;
        for (int k = 0; k < 2; k++) begin
            int          tgt;
            bit          allow;
            bit          hs;
            bit          egnt;
            logic [4:0]  ereq;
            string       nm;
            nm    = (k == 0) ? "errslv" : "dflslv";
            tgt   = model_tgt(addr, int'(c), k == 0, k == 0);
            allow = (m_cnt[k] == 0) || (tgt == m_last[k] && m_cnt[k] < 2);
            ereq  = 5'b0;
            egnt  = 1'b0;
            if (allow) begin
                if (tgt == 5) begin
                    egnt = req;
                end else begin
                    ereq = req ? 5'(1 << tgt) : 5'b0;
                    egnt = gnt[tgt];
                end
            end
            check_eq({nm, ".req_o"}, 32'(req_o[k]), 32'(ereq));
            check_eq({nm, ".gnt_o"}, 32'(gnt_o[k]), 32'(egnt));
            check_eq({nm, ".err_rv"}, 32'(errv_o[k]), 32'(m_err[k]));
            check_eq({nm, ".err_o"}, 32'(err_o[k]), 32'(m_err[k]));
            check_eq({nm, ".cnt"}, 32'(dut_cnt(k)), 32'(m_cnt[k]));
            hs = req && egnt;
            if ((rv[k] || m_err[k]) && m_cnt[k] > 0) m_cnt[k]--;
            if (hs) begin
                m_cnt[k]++;
                m_last[k] = tgt;
            end
            m_err[k] = hs && (tgt == 5);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [4:0]  c;
        int          base;
        rst_n = 1'b0;
        cid   = 5'd1;
        req_i = 1'b1;
        add_i = 32'h1063_0000;
        gnt_i = 5'b00000;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst.cnt", 32'(dut_cnt(0)), 32'd0);
        check_eq("rst.err_rv", 32'(errv_o[0]), 32'd0);
        check_eq("rst.err_o", 32'(err_o[0]), 32'd0);
        check_eq("rst.req_o", 32'(req_o[0]), 32'h08);
        check_eq("rst.id", 32'(id_o[0]), 32'd1);
        req_i = 1'b0;
        rst_n = 1'b1;

        // Decode into slave 3.
        step(5'd1, 1'b1, 32'h1063_0000, 5'b01000, 1'b0, 1'b0);
        check_eq("dec.req_o", 32'(req_o[0]), 32'h08);
        check_eq("dec.gnt_o", 32'(gnt_o[0]), 32'd1);
        step(5'd1, 1'b0, 32'h1063_0000, 5'b00000, 1'b1, 1'b1);
        check_eq("dec.cnt1", 32'(dut_cnt(0)), 32'd1);
        // Clamp to default port, then unmapped address.
        step(5'd1, 1'b1, 32'h106F_0000, 5'b00000, 1'b0, 1'b0);
        check_eq("clamp.req_o", 32'(req_o[0]), 32'h10);
        step(5'd1, 1'b1, 32'h2000_0000, 5'b00000, 1'b0, 1'b0);
        check_eq("miss.dfl.req_o", 32'(req_o[1]), 32'h10);
        check_eq("miss.err.req_o", 32'(req_o[0]), 32'h00);
        check_eq("miss.err.gnt_o", 32'(gnt_o[0]), 32'd1);
        step(5'd1, 1'b0, 32'h2000_0000, 5'b00000, 1'b0, 1'b0);
        check_eq("errrsp.valid", 32'(errv_o[0]), 32'd1);
        step(5'd1, 1'b0, 32'h2000_0000, 5'b00000, 1'b0, 1'b0);
        check_eq("errrsp.once", 32'(errv_o[0]), 32'd0);
        check_eq("errrsp.cnt0", 32'(dut_cnt(0)), 32'd0);

        // Same-target streaming up to full.
        for (int i = 0; i < 3; i++) step(5'd1, 1'b1, 32'h1062_0000, 5'b00100, 1'b0, 1'b0);
        check_eq("full.stall.gnt", 32'(gnt_o[0]), 32'd0);
        check_eq("full.stall.req", 32'(req_o[0]), 32'd0);
        step(5'd1, 1'b1, 32'h1062_0000, 5'b00100, 1'b1, 1'b1);
        check_eq("full.rv.gnt", 32'(gnt_o[0]), 32'd0);
        step(5'd1, 1'b1, 32'h1062_0000, 5'b00100, 1'b0, 1'b0);
        check_eq("full.resume.gnt", 32'(gnt_o[0]), 32'd1);
        check_eq("full.resume.req", 32'(req_o[0]), 32'h04);
        repeat (2) step(5'd1, 1'b0, 32'h0, 5'b00000, 1'b1, 1'b1);

        // Target switch waits for drain.
        step(5'd1, 1'b1, 32'h1061_0000, 5'b00010, 1'b0, 1'b0);
        step(5'd1, 1'b1, 32'h1063_0000, 5'b01000, 1'b0, 1'b0);
        check_eq("switch.stall", 32'(gnt_o[0]), 32'd0);
        step(5'd1, 1'b1, 32'h1063_0000, 5'b01000, 1'b1, 1'b1);
        step(5'd1, 1'b1, 32'h1063_0000, 5'b01000, 1'b0, 1'b0);
        check_eq("switch.req_o", 32'(req_o[0]), 32'h08);
        step(5'd1, 1'b0, 32'h0, 5'b00000, 1'b1, 1'b1);

        // Back-to-back error handshakes overlapping their responses.
        for (int i = 0; i < 3; i++) step(5'd1, 1'b1, 32'h2000_0000, 5'b00000, 1'b0, 1'b0);
        check_eq("b2b.err_rv", 32'(errv_o[0]), 32'd1);
        check_eq("b2b.cnt", 32'(dut_cnt(0)), 32'd1);
        step(5'd1, 1'b0, 32'h0, 5'b00000, 1'b0, 1'b0);

        // Asynchronous reset with two outstanding.
        repeat (2) step(5'd1, 1'b1, 32'h1062_0000, 5'b00100, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("prerst.cnt", 32'(dut_cnt(0)), 32'd2);
        req_i = 1'b0;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst.cnt", 32'(dut_cnt(0)), 32'd0);
        check_eq("midrst.err_rv", 32'(errv_o[0]), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Stray response with nothing outstanding.
        step(5'd1, 1'b0, 32'h0, 5'b00000, 1'b1, 1'b1);
        step(5'd1, 1'b0, 32'h0, 5'b00000, 1'b0, 1'b0);
        check_eq("stray.cnt", 32'(dut_cnt(0)), 32'd0);

        // Randomised traffic.
        c = 5'd1;
        a = 32'h1062_0000;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) c = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) begin
                base = (256 + int'(c) * 4 + 2) % 4096;
                case ($urandom_range(0, 3))
                    0: a = {12'(base), 4'($urandom_range(0, 15)), 16'($urandom)};
                    1: a = {12'h002, 4'($urandom_range(0, 15)), 16'($urandom)};
                    2: a = $urandom;
                    default: a = {12'(base), 4'($urandom_range(0, 2)), 16'($urandom)};
                endcase
            end
            step(c, $urandom_range(0, 3) != 0, a, 5'($urandom),
                 (m_cnt[0] > 0) && !m_err[0] && ($urandom_range(0, 2) == 0),
                 (m_cnt[1] > 0) && !m_err[1] && ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
